// File: rtl/fb_rect_fill.sv
// fb_rect_fill: command-driven rectangle fill engine feeding the downscaled
// framebuffer BRAM write port, one 8-bit pixel per clock.
// Pixel index = y*FB_WIDTH + x; byte lane = index[1:0], matching scan-out.
// Optional feature macro: RECT_FILL_CLIP_EN
//   undefined -> out-of-bounds rectangles are rejected (done + err)
//   defined   -> rectangles are clipped to the framebuffer, err never set
module fb_rect_fill #(
   parameter int FB_WIDTH         = 400,
   parameter int FB_HEIGHT        = 300,
   parameter int X_BITS           = 9,
   parameter int Y_BITS           = 9,
   parameter int BUFFER_ADDR_BITS = 17,
   parameter int CHANNEL_BITS     = 2
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [X_BITS-1:0]         cmd_x,
   input  logic [Y_BITS-1:0]         cmd_y,
   input  logic [X_BITS-1:0]         cmd_w,
   input  logic [Y_BITS-1:0]         cmd_h,
   input  logic [3*CHANNEL_BITS-1:0] cmd_color,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [31:0]               buffer_addr,
   output logic [31:0]               buffer_din,
   output logic                      buffer_en,
   output logic                      buffer_rst,
   output logic [3:0]                buffer_we
);

   localparam int PIX_BITS = 3 * CHANNEL_BITS;
   localparam int A        = BUFFER_ADDR_BITS;
   localparam int XW       = X_BITS + 1;
   localparam int YW       = Y_BITS + 1;
   localparam logic [XW-1:0] FB_W_X = XW'(FB_WIDTH);
   localparam logic [YW-1:0] FB_H_Y = YW'(FB_HEIGHT);
   localparam logic [A-1:0]  FB_W_A = A'(FB_WIDTH);
   localparam logic [XW-1:0] X_ONE  = XW'(1);
   localparam logic [YW-1:0] Y_ONE  = YW'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_FILL  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                state_r;
   logic [X_BITS-1:0]     x_r;
   logic [Y_BITS-1:0]     y_r;
   logic [X_BITS-1:0]     w_r;
   logic [Y_BITS-1:0]     h_r;
   logic [PIX_BITS-1:0]   color_r;
   logic [XW-1:0]         x_end_r;
   logic [YW-1:0]         y_end_r;
   logic [XW-1:0]         cur_x_r;
   logic [YW-1:0]         cur_y_r;
   logic [A-1:0]          row_base_r;
   logic [A-1:0]          addr_r;

   logic [XW-1:0]         x_sum_s;
   logic [YW-1:0]         y_sum_s;
   logic [XW-1:0]         x_end_s;
   logic [YW-1:0]         y_end_s;
   logic                  empty_s;
   logic                  reject_s;
   logic [A-1:0]          first_base_s;
   logic [A-1:0]          first_addr_s;
   logic [XW-1:0]         cur_x_inc_s;
   logic                  last_col_s;
   logic                  last_row_s;
   logic [XW-1:0]         next_x_s;
   logic [YW-1:0]         next_y_s;
   logic [A-1:0]          next_base_s;
   logic [A-1:0]          next_addr_s;
   logic [7:0]            pix_s;

   assign buffer_rst  = 1'b0;
   assign buffer_addr = {{(32-A){1'b0}}, addr_r};
   assign pix_s       = {{(8-PIX_BITS){1'b0}}, color_r};

   // Rectangle extent, bounds decision and first-pixel address for CHECK.
   always_comb begin
      x_sum_s = {1'b0, x_r} + {1'b0, w_r};
      y_sum_s = {1'b0, y_r} + {1'b0, h_r};
`ifdef RECT_FILL_CLIP_EN
      if (x_sum_s > FB_W_X) begin
         x_end_s = FB_W_X;
      end else begin
         x_end_s = x_sum_s;
      end
      if (y_sum_s > FB_H_Y) begin
         y_end_s = FB_H_Y;
      end else begin
         y_end_s = y_sum_s;
      end
      // Clipped width/height of zero covers x>=FB_WIDTH and y>=FB_HEIGHT too.
      empty_s  = (x_end_s <= {1'b0, x_r}) || (y_end_s <= {1'b0, y_r});
      reject_s = 1'b0;
`else
      x_end_s  = x_sum_s;
      y_end_s  = y_sum_s;
      empty_s  = (w_r == {X_BITS{1'b0}}) || (h_r == {Y_BITS{1'b0}});
      reject_s = !empty_s &&
                 (({1'b0, x_r} >= FB_W_X) || ({1'b0, y_r} >= FB_H_Y) ||
                  (x_sum_s > FB_W_X) || (y_sum_s > FB_H_Y));
`endif
      first_base_s = A'(y_r) * FB_W_A;
      first_addr_s = first_base_s + A'(x_r);
   end

   // Next pixel in raster order; rows advance by adding FB_WIDTH to the base.
   always_comb begin
      cur_x_inc_s = cur_x_r + X_ONE;
      last_col_s  = (cur_x_inc_s == x_end_r);
      last_row_s  = ((cur_y_r + Y_ONE) == y_end_r);
      if (last_col_s) begin
         next_x_s    = {1'b0, x_r};
         next_y_s    = cur_y_r + Y_ONE;
         next_base_s = row_base_r + FB_W_A;
      end else begin
         next_x_s    = cur_x_inc_s;
         next_y_s    = cur_y_r;
         next_base_s = row_base_r;
      end
      next_addr_s = next_base_s + A'(next_x_s);
   end

   // Control FSM with registered handshake, status and BRAM write outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r    <= ST_IDLE;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         addr_r     <= {A{1'b0}};
         buffer_din <= 32'h0000_0000;
         buffer_en  <= 1'b0;
         buffer_we  <= 4'b0000;
         x_r        <= {X_BITS{1'b0}};
         y_r        <= {Y_BITS{1'b0}};
         w_r        <= {X_BITS{1'b0}};
         h_r        <= {Y_BITS{1'b0}};
         color_r    <= {PIX_BITS{1'b0}};
         x_end_r    <= {XW{1'b0}};
         y_end_r    <= {YW{1'b0}};
         cur_x_r    <= {XW{1'b0}};
         cur_y_r    <= {YW{1'b0}};
         row_base_r <= {A{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (cmd_valid && cmd_ready) begin
                  x_r       <= cmd_x;
                  y_r       <= cmd_y;
                  w_r       <= cmd_w;
                  h_r       <= cmd_h;
                  color_r   <= cmd_color;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state_r   <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               x_end_r <= x_end_s;
               y_end_r <= y_end_s;
               if (empty_s || reject_s) begin
                  done    <= 1'b1;
                  err     <= reject_s;
                  state_r <= ST_DONE;
               end else begin
                  cur_x_r    <= {1'b0, x_r};
                  cur_y_r    <= {1'b0, y_r};
                  row_base_r <= first_base_s;
                  addr_r     <= first_addr_s;
                  buffer_en  <= 1'b1;
                  buffer_we  <= 4'b0001 << first_addr_s[1:0];
                  buffer_din <= {4{pix_s}};
                  state_r    <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (last_col_s && last_row_s) begin
                  buffer_en <= 1'b0;
                  buffer_we <= 4'b0000;
                  done      <= 1'b1;
                  err       <= 1'b0;
                  state_r   <= ST_DONE;
               end else begin
                  cur_x_r    <= next_x_s;
                  cur_y_r    <= next_y_s;
                  row_base_r <= next_base_s;
                  addr_r     <= next_addr_s;
                  buffer_we  <= 4'b0001 << next_addr_s[1:0];
               end
            end
            ST_DONE: begin
               done      <= 1'b0;
               err       <= 1'b0;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
               state_r   <= ST_IDLE;
            end
            default: begin
               buffer_en <= 1'b0;
               buffer_we <= 4'b0000;
               done      <= 1'b0;
               err       <= 1'b0;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: table of rectangles with hand-computed
// write counts, first address/lane and error flag, plus hand-written
// sequences for back-to-back commands and reset during a fill.
module tb_fb_rect_fill;

   logic        clk;
   logic        resetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [8:0]  cmd_x;
   logic [8:0]  cmd_y;
   logic [8:0]  cmd_w;
   logic [8:0]  cmd_h;
   logic [5:0]  cmd_color;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] buffer_addr;
   logic [31:0] buffer_din;
   logic        buffer_en;
   logic        buffer_rst;
   logic [3:0]  buffer_we;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      int         x;
      int         y;
      int         w;
      int         h;
      logic [5:0] color;
      int         exp_n;
      logic       exp_err;
      logic [31:0] first_addr;
      logic [3:0] first_we;
   } rec_t;

   rec_t vec [9];

   fb_rect_fill dut (
      .clk         (clk),
      .resetn      (resetn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_x       (cmd_x),
      .cmd_y       (cmd_y),
      .cmd_w       (cmd_w),
      .cmd_h       (cmd_h),
      .cmd_color   (cmd_color),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .buffer_addr (buffer_addr),
      .buffer_din  (buffer_din),
      .buffer_en   (buffer_en),
      .buffer_rst  (buffer_rst),
      .buffer_we   (buffer_we)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_addr"}, buffer_addr, 32'd0);
      chk({tag, "_din"}, buffer_din, 32'd0);
      chk({tag, "_en"}, 32'(buffer_en), 32'd0);
      chk({tag, "_we"}, 32'(buffer_we), 32'd0);
      chk({tag, "_rst"}, 32'(buffer_rst), 32'd0);
   endtask

   // Present a command in IDLE and return just after the accepting edge.
   task automatic issue(input rec_t r, input bit keep_valid);
      @(negedge clk);
      cmd_x     = 9'(r.x);
      cmd_y     = 9'(r.y);
      cmd_w     = 9'(r.w);
      cmd_h     = 9'(r.h);
      cmd_color = r.color;
      cmd_valid = 1'b1;
      chk({r.name, "_ready_idle"}, 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      if (!keep_valid) begin
         cmd_valid = 1'b0;
         cmd_x     = 9'($urandom);
         cmd_y     = 9'($urandom);
         cmd_w     = 9'($urandom);
         cmd_h     = 9'($urandom);
         cmd_color = 6'($urandom);
      end
   endtask

   // Follow one accepted command to its done pulse, checking every write.
   task automatic observe(input rec_t r);
      int n, dk, cx, cy, xe, ye;
      logic [31:0] ea;
      logic [7:0]  pix;
      xe = r.x + r.w;
      ye = r.y + r.h;
`ifdef RECT_FILL_CLIP_EN
      if (xe > 400) xe = 400;
      if (ye > 300) ye = 300;
`endif
      cx = r.x; cy = r.y; n = 0; dk = -1;
      pix = {2'b00, r.color};
      for (int k = 1; k <= r.exp_n + 6 && dk < 0; k++) begin
         @(negedge clk);
         chk({r.name, "_busy"}, 32'(busy), 32'd1);
         chk({r.name, "_ready_busy"}, 32'(cmd_ready), 32'd0);
         if (buffer_en) begin
            ea = 32'(cy * 400 + cx);
            chk({r.name, "_wr_cycle"}, 32'(k), 32'(n + 2));
            chk({r.name, "_addr"}, buffer_addr, ea);
            chk({r.name, "_we"}, 32'(buffer_we), 32'(4'b0001 << ea[1:0]));
            chk({r.name, "_din"}, buffer_din, {4{pix}});
            if (n == 0) begin
               chk({r.name, "_first_addr"}, buffer_addr, r.first_addr);
               chk({r.name, "_first_we"}, 32'(buffer_we), 32'(r.first_we));
            end
            n++;
            cx++;
            if (cx >= xe) begin
               cx = r.x;
               cy++;
            end
         end else begin
            chk({r.name, "_we_idle"}, 32'(buffer_we), 32'd0);
         end
         if (done) begin
            dk = k;
            chk({r.name, "_err"}, 32'(err), 32'(r.exp_err));
         end else begin
            chk({r.name, "_err_nodone"}, 32'(err), 32'd0);
         end
      end
      chk({r.name, "_n_writes"}, 32'(n), 32'(r.exp_n));
      chk({r.name, "_done_cycle"}, 32'(dk), 32'(r.exp_n + 2));
   endtask

   initial begin
      rec_t r1, r2, rr;

      // name, x, y, w, h, colour, writes, err, first addr, first we
      vec[0] = '{"basic",     3,   0,   2,   2, 6'h2A,   4, 1'b0, 32'd3,      4'b1000};
      vec[1] = '{"last_rows", 0,   298, 400, 2, 6'h3F,   800, 1'b0, 32'd119200, 4'b0001};
      vec[2] = '{"w_zero",    10,  10,  0,   5, 6'h01,   0, 1'b0, 32'd0,      4'b0000};
      vec[3] = '{"h_zero",    10,  10,  5,   0, 6'h02,   0, 1'b0, 32'd0,      4'b0000};
      vec[4] = '{"corner",    399, 299, 1,   1, 6'h3F,   1, 1'b0, 32'd119999, 4'b1000};
      vec[5] = '{"mid",       5,   7,   3,   2, 6'h07,   6, 1'b0, 32'd2805,   4'b0010};
`ifdef RECT_FILL_CLIP_EN
      vec[6] = '{"x_over",    398, 0,   4,   1, 6'h15,   2, 1'b0, 32'd398,    4'b0100};
      vec[7] = '{"x_outside", 400, 0,   1,   1, 6'h15,   0, 1'b0, 32'd0,      4'b0000};
      vec[8] = '{"y_over",    0,   290, 10,  12, 6'h33,  100, 1'b0, 32'd116000, 4'b0001};
`else
      vec[6] = '{"x_over",    398, 0,   4,   1, 6'h15,   0, 1'b1, 32'd0,      4'b0000};
      vec[7] = '{"x_outside", 400, 0,   1,   1, 6'h15,   0, 1'b1, 32'd0,      4'b0000};
      vec[8] = '{"y_over",    0,   290, 10,  12, 6'h33,  0, 1'b1, 32'd0,      4'b0000};
`endif

      resetn    = 1'b1;
      cmd_valid = 1'b0;
      cmd_x     = 9'd0;
      cmd_y     = 9'd0;
      cmd_w     = 9'd0;
      cmd_h     = 9'd0;
      cmd_color = 6'd0;
      #1 resetn = 1'b0;
      #2 chk_reset_values("reset");
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 9; i++) begin
         issue(vec[i], 1'b0);
         observe(vec[i]);
      end

      // Second command held on cmd_valid during a fill.
      r1 = '{"b2b_first",  20, 20, 3, 1, 6'h11, 3, 1'b0, 32'd8020,  4'b0001};
      r2 = '{"b2b_second", 30, 30, 2, 1, 6'h22, 2, 1'b0, 32'd12030, 4'b0100};
      issue(r1, 1'b1);
      cmd_x     = 9'(r2.x);
      cmd_y     = 9'(r2.y);
      cmd_w     = 9'(r2.w);
      cmd_h     = 9'(r2.h);
      cmd_color = r2.color;
      observe(r1);
      @(negedge clk);
      chk("b2b_ready_after_done", 32'(cmd_ready), 32'd1);
      chk("b2b_done_cleared", 32'(done), 32'd0);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      observe(r2);

      // Reset asserted in the middle of a fill.
      rr = '{"rst_fill", 0, 0, 50, 1, 6'h0C, 50, 1'b0, 32'd0, 4'b0001};
      issue(rr, 1'b0);
      repeat (5) @(negedge clk);
      chk("rst_pre_en", 32'(buffer_en), 32'd1);
      #2 resetn = 1'b0;
      #1 chk_reset_values("rst_async");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_hold_en", 32'(buffer_en), 32'd0);
         chk("rst_hold_done", 32'(done), 32'd0);
      end
      resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_after_en", 32'(buffer_en), 32'd0);
         chk("rst_after_done", 32'(done), 32'd0);
      end
      issue(vec[5], 1'b0);
      observe(vec[5]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
